// File: rtl/dmaw_2_axi_mo.sv
// DMA 1D write request -> AXI3 INCR write bursts with multiple outstanding AWs.
// Optional: define DMAW_BRESP_CHK_EN to report non-OKAY bresp / non-zero bid via dma_w_err.
module dmaw_2_axi_mo #(
  parameter int unsigned DW         = 32,
  parameter int unsigned MAX_BLEN   = 16,
  parameter int unsigned OUTS       = 4,
  parameter int unsigned WCMD_THRES = 12,
  parameter int unsigned BW         = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            cfg_bf,
  input  logic            cfg_cf,
  input  logic            cfg_dma_halt,
  input  logic [BW-1:0]   buf_word,
  input  logic            dma_w_req,
  output logic            dma_w_ack,
  input  logic [31:0]     dma_w_addr,
  input  logic [15:0]     dma_w_len,
  input  logic [DW-1:0]   dma_wdata,
  input  logic [DW/8-1:0] dma_wbe,
  output logic            dma_w_dack,
  output logic            dma_w_done,
  output logic            dma_w_err,
  output logic [3:0]      awid,
  output logic [31:0]     awaddr,
  output logic [3:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [1:0]      awlock,
  output logic [3:0]      awcache,
  output logic [2:0]      awprot,
  output logic            awvalid,
  input  logic            awready,
  output logic [3:0]      wid,
  output logic [DW-1:0]   wdata,
  output logic [DW/8-1:0] wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [3:0]      bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  localparam int unsigned BYTES = DW / 8;
  localparam int unsigned LSB   = $clog2(BYTES);
  localparam int unsigned QAW   = $clog2(OUTS);
  localparam int unsigned CW    = QAW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CMD, S_DRAIN} state_t;

  state_t        state;
  logic [31:0]   req_addr;
  logic [15:0]   req_len;
  logic [31:0]   cur_addr;
  logic [16:0]   rem_beats;
  logic [CW-1:0] outs_cnt;

  logic [3:0]     q_mem [OUTS];
  logic [QAW-1:0] q_wp, q_rp;
  logic [CW-1:0]  q_cnt;
  logic           q_full, q_empty, q_push, q_pop;

  logic       w_active;
  logic [3:0] beat_cnt;

  logic        aw_hs, w_hs, b_hs, aw_ok, accept;
  logic [16:0] beats, lim_4k, aw_beats;
  logic [31:0] buf_ext;

  assign aw_hs    = awvalid & awready;
  assign w_hs     = wvalid & wready;
  assign b_hs     = bvalid & bready;
  assign accept   = (state == S_IDLE) && dma_w_req && !cfg_dma_halt;
  assign q_full   = (q_cnt == CW'(OUTS));
  assign q_empty  = (q_cnt == '0);
  assign q_push   = aw_hs;
  assign q_pop    = !q_empty && (!w_active || (w_hs && beat_cnt == 4'd0));
  assign lim_4k   = 17'((13'h1000 - {1'b0, cur_addr[11:0]}) >> LSB);
  assign aw_beats = 17'(awlen) + 17'd1;
  assign buf_ext  = 32'(buf_word);

  always_comb begin
    beats = rem_beats;
    if (beats > 17'(MAX_BLEN)) beats = 17'(MAX_BLEN);
    if (beats > lim_4k) beats = lim_4k;
  end

  assign aw_ok = !q_full && (outs_cnt < CW'(OUTS)) && !cfg_dma_halt &&
                 ((buf_ext >= 32'(WCMD_THRES)) || (buf_ext >= 32'(beats)));

  // Splitter: awaddr/awlen are latched when awvalid rises and held until awready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      req_addr   <= '0;
      req_len    <= '0;
      cur_addr   <= '0;
      rem_beats  <= '0;
      awvalid    <= 1'b0;
      awaddr     <= '0;
      awlen      <= '0;
      awcache    <= '0;
      dma_w_ack  <= 1'b0;
      dma_w_done <= 1'b0;
    end else begin
      dma_w_ack  <= 1'b0;
      dma_w_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            dma_w_ack <= 1'b1;
            req_addr  <= dma_w_addr;
            req_len   <= dma_w_len;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          cur_addr  <= {req_addr[31:LSB], {LSB{1'b0}}};
          rem_beats <= ((17'(req_addr[LSB-1:0]) + 17'(req_len)) >> LSB) + 17'd1;
          state     <= S_CMD;
        end
        S_CMD: begin
          if (awvalid) begin
            if (awready) begin
              awvalid   <= 1'b0;
              cur_addr  <= cur_addr + (32'(aw_beats) << LSB);
              rem_beats <= rem_beats - aw_beats;
              if (rem_beats == aw_beats) state <= S_DRAIN;
            end
          end else if (aw_ok) begin
            awvalid <= 1'b1;
            awaddr  <= cur_addr;
            awlen   <= 4'(beats - 17'd1);
            awcache <= {2'b00, cfg_cf, cfg_bf};
          end
        end
        S_DRAIN: begin
          if (outs_cnt == '0 && q_empty) begin
            dma_w_done <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A B with nothing outstanding is ignored; it cannot cancel a same-cycle AW.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outs_cnt <= '0;
    end else if (aw_hs && !b_hs) begin
      outs_cnt <= outs_cnt + CW'(1);
    end else if (b_hs && !aw_hs && outs_cnt != '0) begin
      outs_cnt <= outs_cnt - CW'(1);
    end else if (aw_hs && b_hs && outs_cnt == '0) begin
      outs_cnt <= outs_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (q_push) q_mem[q_wp] <= awlen;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_wp     <= '0;
      q_rp     <= '0;
      q_cnt    <= '0;
      w_active <= 1'b0;
      beat_cnt <= '0;
    end else begin
      if (q_push) q_wp <= q_wp + QAW'(1);
      if (q_pop) q_rp <= q_rp + QAW'(1);
      if (q_push && !q_pop) q_cnt <= q_cnt + CW'(1);
      else if (!q_push && q_pop) q_cnt <= q_cnt - CW'(1);
      // Next entry loads on the last beat so consecutive bursts stream without a gap.
      if (q_pop) begin
        w_active <= 1'b1;
        beat_cnt <= q_mem[q_rp];
      end else if (w_hs) begin
        if (beat_cnt == 4'd0) w_active <= 1'b0;
        else beat_cnt <= beat_cnt - 4'd1;
      end
    end
  end

`ifdef DMAW_BRESP_CHK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dma_w_err <= 1'b0;
    end else if (accept) begin
      dma_w_err <= 1'b0;
    end else if (b_hs && (bresp != 2'b00 || bid != 4'h0)) begin
      dma_w_err <= 1'b1;
    end
  end
`else
  logic unused_b;
  assign unused_b  = ^{bresp, bid};
  assign dma_w_err = 1'b0;
`endif

  assign awid       = 4'h0;
  assign awsize     = 3'(LSB);
  assign awburst    = 2'b01;
  assign awlock     = 2'b00;
  assign awprot     = 3'b010;
  assign wvalid     = w_active;
  assign wlast      = w_active && (beat_cnt == 4'd0);
  assign wid        = 4'h0;
  assign wdata      = w_active ? dma_wdata : '0;
  assign wstrb      = w_active ? dma_wbe : '0;
  assign dma_w_dack = w_hs;
  assign bready     = 1'b1;

endmodule

// File: tb/tb_dmaw_2_axi_mo.sv
// Self-checking bench for dmaw_2_axi_mo: randomized AXI slave plus a burst-splitting reference model.
`timescale 1ns/1ps
module tb_dmaw_2_axi_mo;

  localparam int unsigned DW       = 32;
  localparam int unsigned BYTES    = DW / 8;
  localparam int unsigned LSB      = $clog2(BYTES);
  localparam int unsigned MAX_BLEN = 16;
  localparam int unsigned OUTS     = 4;
`ifdef DMAW_BRESP_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0, rstn = 1'b0;
  logic cfg_bf = 0, cfg_cf = 0, cfg_dma_halt = 0;
  logic [7:0] buf_word = 8'd32;
  logic dma_w_req = 0, dma_w_ack, dma_w_dack, dma_w_done, dma_w_err;
  logic [31:0] dma_w_addr = 0;
  logic [15:0] dma_w_len = 0;
  logic [DW-1:0] dma_wdata = 0;
  logic [BYTES-1:0] dma_wbe = 0;
  logic [3:0] awid, awlen, awcache, wid, bid = 0;
  logic [31:0] awaddr;
  logic [2:0] awsize, awprot;
  logic [1:0] awburst, awlock, bresp = 0;
  logic awvalid, awready = 0, wlast, wvalid, wready = 0, bvalid = 0, bready;
  logic [DW-1:0] wdata;
  logic [BYTES-1:0] wstrb;

  dmaw_2_axi_mo #(.DW(DW), .MAX_BLEN(MAX_BLEN), .OUTS(OUTS), .WCMD_THRES(12), .BW(8)) dut (
    .clk(clk), .rstn(rstn), .cfg_bf(cfg_bf), .cfg_cf(cfg_cf), .cfg_dma_halt(cfg_dma_halt),
    .buf_word(buf_word), .dma_w_req(dma_w_req), .dma_w_ack(dma_w_ack),
    .dma_w_addr(dma_w_addr), .dma_w_len(dma_w_len), .dma_wdata(dma_wdata), .dma_wbe(dma_wbe),
    .dma_w_dack(dma_w_dack), .dma_w_done(dma_w_done), .dma_w_err(dma_w_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave / monitor state
  bit aw_rand = 0, w_rand = 0, b_hold = 0;
  int err_b_idx = -1, b_seen = 0, b_pend = 0, outs_now = 0;
  int w_idx = 0, w_beats = 0, w_bad = 0, aw_bad = 0, outs_bad = 0;
  logic [31:0] aw_addr_q[$];
  int aw_len_q[$], w_exp[$], beat_cyc[$];
  logic [31:0] exp_addr[$];
  int exp_len[$];

  // Drive slave inputs on the falling edge, sample the coming handshakes 1ns later.
  always begin
    @(negedge clk);
    if (!rstn) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    end else begin
      awready   = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      wready    = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      dma_wdata = DW'($urandom);
      dma_wbe   = BYTES'($urandom);
      if (!b_hold && b_pend > 0) begin
        bvalid = 1; bid = 0;
        bresp = (b_seen == err_b_idx) ? 2'b10 : 2'b00;
      end else begin
        bvalid = 0; bresp = 0;
      end
      #1;
      if (awvalid && awready) begin
        aw_addr_q.push_back(awaddr);
        aw_len_q.push_back(int'(awlen));
        w_exp.push_back(int'(awlen) + 1);
        outs_now++;
        if (outs_now > OUTS) outs_bad++;
        if (awid !== 4'h0 || awsize !== 3'(LSB) || awburst !== 2'b01 || awlock !== 2'b00 ||
            awprot !== 3'b010 || awcache !== {2'b00, cfg_cf, cfg_bf}) aw_bad++;
      end
      if (wvalid && wready) begin
        w_beats++;
        beat_cyc.push_back(cyc);
        if (wdata !== dma_wdata || wstrb !== dma_wbe || wid !== 4'h0 || dma_w_dack !== 1'b1)
          w_bad++;
        if (w_exp.size() == 0) w_bad++;
        else begin
          w_idx++;
          if (wlast !== (w_idx == w_exp[0])) w_bad++;
          if (w_idx >= w_exp[0]) begin
            void'(w_exp.pop_front());
            w_idx = 0;
          end
        end
        if (wlast) b_pend++;
      end else if (dma_w_dack !== 1'b0) w_bad++;
      if (bvalid && bready) begin
        b_pend--; b_seen++; outs_now--;
      end
    end
  end

  task automatic apply_reset();
    rstn = 0;
    repeat (3) @(negedge clk);
    aw_addr_q.delete(); aw_len_q.delete(); w_exp.delete(); beat_cyc.delete();
    b_pend = 0; b_seen = 0; outs_now = 0; w_idx = 0; w_beats = 0;
    #2 rstn = 1;
  endtask

  task automatic clear_rec();
    aw_addr_q.delete(); aw_len_q.delete(); beat_cyc.delete();
    w_beats = 0; b_seen = 0;
  endtask

  // Reference: walk beat-aligned addresses, cut at MAX_BLEN and every 4KB boundary.
  task automatic build_model(input longint a, input longint l);
    longint cur, last_beat, rem, to4k, nb;
    exp_addr.delete(); exp_len.delete();
    cur = a - (a % BYTES);
    last_beat = (a + l) - ((a + l) % BYTES);
    while (cur <= last_beat) begin
      rem  = (last_beat - cur) / BYTES + 1;
      to4k = (4096 - (cur % 4096)) / BYTES;
      nb = rem;
      if (nb > MAX_BLEN) nb = MAX_BLEN;
      if (nb > to4k) nb = to4k;
      exp_addr.push_back(cur[31:0]);
      exp_len.push_back(int'(nb) - 1);
      cur += nb * BYTES;
    end
  endtask

  function automatic int seq_diff();
    if (aw_addr_q.size() != exp_addr.size()) return -2;
    foreach (exp_addr[i])
      if (aw_addr_q[i] !== exp_addr[i] || aw_len_q[i] != exp_len[i]) return i;
    return -1;
  endfunction

  function automatic int model_beats();
    int s = 0;
    foreach (exp_len[i]) s += exp_len[i] + 1;
    return s;
  endfunction

  task automatic start_req(input logic [31:0] a, input logic [15:0] l, input int bound,
                           output bit ok);
    @(negedge clk);
    clear_rec();
    dma_w_addr = a; dma_w_len = l; dma_w_req = 1;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #2;
      if (dma_w_ack) begin ok = 1; break; end
    end
    dma_w_req = 0;
  endtask

  task automatic wait_done(input int bound, output bit ok, output logic err);
    ok = 0; err = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #2;
      if (dma_w_done) begin ok = 1; err = dma_w_err; break; end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk); #2;
    checks++;
    if ({awvalid, wvalid, wlast, dma_w_ack, dma_w_done, dma_w_err, dma_w_dack} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {awvalid, wvalid, wlast, dma_w_ack, dma_w_done, dma_w_err, dma_w_dack});
    end
    checks++;
    if (awsize !== 3'(LSB) || bready !== 1'b1) begin
      failures++;
      $display("FAIL reset_size_bready: got %0d/%b want %0d/1", awsize, bready, LSB);
    end
    checks++;
    if ({awburst, awprot, awlock, awid, awcache} !== {2'b01, 3'b010, 2'b00, 4'h0, 4'h0}) begin
      failures++;
      $display("FAIL reset_aw_attr: got %h want %h", {awburst, awprot, awlock, awid, awcache},
               {2'b01, 3'b010, 2'b00, 4'h0, 4'h0});
    end
    checks++;
    if (awaddr !== 32'h0 || awlen !== 4'h0 || wdata !== '0 || wstrb !== '0) begin
      failures++;
      $display("FAIL reset_data: got awaddr=%h awlen=%h wdata=%h wstrb=%h want 0",
               awaddr, awlen, wdata, wstrb);
    end
  endtask

  task automatic test_single();
    bit ok_a, ok_d; logic err;
    aw_rand = 0; w_rand = 0; buf_word = 32;
    start_req(32'h1000, 16'd63, 50, ok_a);
    wait_done(500, ok_d, err);
    checks++;
    if (!ok_a || !ok_d) begin
      failures++; $display("FAIL single_handshake: got ack=%0d done=%0d want 1/1", ok_a, ok_d);
    end
    checks++;
    if (aw_addr_q.size() != 1 || aw_len_q[0] != 15 || aw_addr_q[0] !== 32'h1000) begin
      failures++;
      $display("FAIL single_aw: got n=%0d want n=1 addr=1000 awlen=15", aw_addr_q.size());
    end
    checks++;
    if (w_beats != 16 || w_bad != 0) begin
      failures++; $display("FAIL single_w: got beats=%0d bad=%0d want 16/0", w_beats, w_bad);
    end
  endtask

  task automatic test_4k();
    bit ok_a, ok_d; logic err;
    aw_rand = 1; w_rand = 1; buf_word = 32;
    build_model(64'h0FF2, 29);
    start_req(32'h0FF2, 16'd29, 50, ok_a);
    wait_done(1000, ok_d, err);
    checks++;
    if (!ok_a || !ok_d || aw_addr_q.size() != 2) begin
      failures++;
      $display("FAIL split_4k_count: got ack=%0d done=%0d n=%0d want 1/1/2", ok_a, ok_d,
               aw_addr_q.size());
    end else begin
      checks++;
      if (aw_addr_q[0] !== 32'h0FF0 || aw_len_q[0] != 3 || aw_addr_q[1] !== 32'h1000 ||
          aw_len_q[1] != 3) begin
        failures++;
        $display("FAIL split_4k_aw: got %h/%0d %h/%0d want 00000ff0/3 00001000/3",
                 aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]);
      end
    end
    checks++;
    if (seq_diff() != -1 || w_beats != 8) begin
      failures++;
      $display("FAIL split_4k_model: got diff=%0d beats=%0d want -1/8", seq_diff(), w_beats);
    end
  endtask

  task automatic test_outs();
    bit ok_a, ok_d; logic err;
    aw_rand = 0; w_rand = 0; buf_word = 32; b_hold = 1;
    build_model(0, 511);
    start_req(32'h0, 16'd511, 50, ok_a);
    repeat (200) @(negedge clk);
    #2;
    checks++;
    if (aw_addr_q.size() != OUTS || awvalid !== 1'b0 || w_beats != 64) begin
      failures++;
      $display("FAIL outs_limit: got n=%0d awvalid=%b beats=%0d want %0d/0/64",
               aw_addr_q.size(), awvalid, w_beats, OUTS);
    end
    b_hold = 0;
    wait_done(2000, ok_d, err);
    checks++;
    if (!ok_a || !ok_d || seq_diff() != -1 || outs_bad != 0) begin
      failures++;
      $display("FAIL outs_resume: got ack=%0d done=%0d diff=%0d outs_bad=%0d want 1/1/-1/0",
               ok_a, ok_d, seq_diff(), outs_bad);
    end
  endtask

  task automatic test_thres_halt();
    bit ok_a, ok_d; logic err;
    aw_rand = 0; w_rand = 0; buf_word = 3;
    start_req(32'h0, 16'd63, 50, ok_a);
    repeat (10) @(negedge clk);
    #2;
    checks++;
    if (awvalid !== 1'b0 || aw_addr_q.size() != 0) begin
      failures++; $display("FAIL thres_block: got awvalid=%b want 0", awvalid);
    end
    @(negedge clk); buf_word = 12;
    @(negedge clk); #2;
    checks++;
    if (awvalid !== 1'b1) begin
      failures++; $display("FAIL thres_release: got awvalid=%b want 1", awvalid);
    end
    wait_done(500, ok_d, err);
    checks++;
    if (!ok_a || !ok_d || w_beats != 16) begin
      failures++; $display("FAIL thres_done: got done=%0d beats=%0d want 1/16", ok_d, w_beats);
    end
    cfg_dma_halt = 1; buf_word = 32;
    start_req(32'h40, 16'd15, 20, ok_a);
    checks++;
    if (ok_a) begin
      failures++; $display("FAIL halt_no_ack: got ack=1 want 0");
    end
    buf_word = 0; cfg_dma_halt = 0;
    start_req(32'h40, 16'd15, 50, ok_a);
    cfg_dma_halt = 1; buf_word = 32;
    repeat (10) @(negedge clk);
    #2;
    checks++;
    if (!ok_a || awvalid !== 1'b0 || aw_addr_q.size() != 0) begin
      failures++;
      $display("FAIL halt_no_aw: got ack=%0d awvalid=%b n=%0d want 1/0/0", ok_a, awvalid,
               aw_addr_q.size());
    end
    cfg_dma_halt = 0;
    build_model(64'h40, 15);
    wait_done(500, ok_d, err);
    checks++;
    if (!ok_d || seq_diff() != -1) begin
      failures++; $display("FAIL halt_resume: got done=%0d diff=%0d want 1/-1", ok_d, seq_diff());
    end
  endtask

  task automatic test_back_to_back();
    bit ok_a, ok_d; logic err;
    aw_rand = 0; w_rand = 0; buf_word = 32;
    build_model(64'h1004, 7);
    start_req(32'h1004, 16'd7, 50, ok_a);
    wait_done(500, ok_d, err);
    checks++;
    if (!ok_d || aw_len_q.size() != 1 || aw_len_q[0] != 1 || seq_diff() != -1) begin
      failures++;
      $display("FAIL unaligned_2beat: got done=%0d diff=%0d want 1/-1", ok_d, seq_diff());
    end
    build_model(0, 255);
    start_req(32'h0, 16'd255, 50, ok_a);
    wait_done(1000, ok_d, err);
    checks++;
    if (!ok_d || beat_cyc.size() != 64 || seq_diff() != -1) begin
      failures++;
      $display("FAIL b2b_seq: got done=%0d beats=%0d diff=%0d want 1/64/-1", ok_d,
               beat_cyc.size(), seq_diff());
    end else begin
      checks++;
      if (beat_cyc[63] - beat_cyc[0] != 63) begin
        failures++;
        $display("FAIL b2b_bubble: got span=%0d want 63", beat_cyc[63] - beat_cyc[0]);
      end
    end
  endtask

  task automatic test_err();
    bit ok_a, ok_d; logic err;
    aw_rand = 1; w_rand = 1; buf_word = 32;
    err_b_idx = 1;
    start_req(32'h0, 16'd191, 50, ok_a);
    wait_done(2000, ok_d, err);
    err_b_idx = -1;
    checks++;
    if (!ok_d || err !== ERR_EN || b_seen != 3) begin
      failures++;
      $display("FAIL err_at_done: got done=%0d err=%b nb=%0d want 1/%b/3", ok_d, err, b_seen,
               ERR_EN);
    end
    start_req(32'h2000, 16'd3, 50, ok_a);
    checks++;
    if (!ok_a || dma_w_err !== 1'b0) begin
      failures++; $display("FAIL err_clear: got ack=%0d err=%b want 1/0", ok_a, dma_w_err);
    end
    wait_done(500, ok_d, err);
    checks++;
    if (!ok_d || err !== 1'b0) begin
      failures++; $display("FAIL err_clean: got done=%0d err=%b want 1/0", ok_d, err);
    end
  endtask

  task automatic test_random();
    bit ok_a, ok_d; logic err;
    logic [31:0] a; logic [15:0] l;
    for (int i = 0; i < 10; i++) begin
      aw_rand = 1; w_rand = 1;
      buf_word = 8'($urandom_range(12, 40));
      cfg_bf = 1'($urandom); cfg_cf = 1'($urandom);
      a = ($urandom & 32'h00FF_F000) |
          ((i % 2 == 1) ? 32'($urandom_range(12'hF00, 12'hFFF)) : 32'($urandom_range(0, 4095)));
      l = (i == 0) ? 16'd9000 : 16'($urandom_range(0, 2047));
      build_model(longint'(a), longint'(l));
      start_req(a, l, 50, ok_a);
      wait_done(30000, ok_d, err);
      checks++;
      if (!ok_a || !ok_d || seq_diff() != -1 || w_beats != model_beats()) begin
        failures++;
        $display("FAIL rand_%0d a=%h l=%0d: got ack=%0d done=%0d diff=%0d beats=%0d want 1/1/-1/%0d",
                 i, a, l, ok_a, ok_d, seq_diff(), w_beats, model_beats());
      end
    end
    checks++;
    if (w_bad != 0 || aw_bad != 0 || outs_bad != 0) begin
      failures++;
      $display("FAIL protocol: got w_bad=%0d aw_bad=%0d outs_bad=%0d want 0/0/0", w_bad, aw_bad,
               outs_bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_4k();
    test_outs();
    test_thres_halt();
    test_back_to_back();
    test_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
